// File: rtl/next_hop_table_if.sv
// Bundle of the next-hop table's clear, configuration and lookup signals.
// The table itself is the slave; the control processor / forwarding engine side is the master.
interface next_hop_table_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 11
);
    localparam int NB = DATA_W / 8;

    logic              clear_start;
    logic              busy;
    logic              cfg_en;
    logic [NB-1:0]     cfg_we;
    logic [ADDR_W-1:0] cfg_addr;
    logic [DATA_W-1:0] cfg_wdata;
    logic [DATA_W-1:0] cfg_rdata;
    logic              cfg_ready;
    logic              lk_req_valid;
    logic              lk_req_ready;
    logic [ADDR_W-1:0] lk_addr;
    logic              lk_resp_valid;
    logic [DATA_W-1:0] lk_resp_data;

    modport slave (
        input  clear_start, cfg_en, cfg_we, cfg_addr, cfg_wdata, lk_req_valid, lk_addr,
        output busy, cfg_rdata, cfg_ready, lk_req_ready, lk_resp_valid, lk_resp_data
    );

    modport master (
        output clear_start, cfg_en, cfg_we, cfg_addr, cfg_wdata, lk_req_valid, lk_addr,
        input  busy, cfg_rdata, cfg_ready, lk_req_ready, lk_resp_valid, lk_resp_data
    );
endinterface

// File: rtl/next_hop_table.sv
// Byte-lane next-hop table: config port, 2-cycle pipelined lookup port with
// same-cycle write forwarding, and a clear engine that sweeps every word.
//
// state | meaning
// IDLE  | normal operation, both ports accept accesses
// CLEAR | writing CLEAR_VALUE to word[cnt_q], ports held off (busy)
module next_hop_table #(
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 11,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = '0,
    parameter bit                INIT_CLEAR  = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    next_hop_table_if.slave tbl_if
);
    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              init_q;
    logic              busy;

    logic              cfg_acc, cfg_rd, lk_acc;
    logic [NB-1:0]     ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] cfg_ram, lk_ram, lk_merged;

    logic              cfg_seen_q;
    logic              lk_v1_q, lk_v2_q;
    logic [NB-1:0]     lk_fwd_mask_q;
    logic [DATA_W-1:0] lk_fwd_data_q;
    logic [DATA_W-1:0] lk_data_q;

    assign busy    = (state_q == CLEAR);
    assign cfg_acc = tbl_if.cfg_en & ~busy;
    assign cfg_rd  = cfg_acc & ~(|tbl_if.cfg_we);
    assign lk_acc  = tbl_if.lk_req_valid & ~busy;

    // init_q lets the automatic clear start on the first edge after reset
    // while keeping busy low for the whole reset interval.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            init_q  <= INIT_CLEAR;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            init_q  <= 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (tbl_if.clear_start || init_q) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {ADDR_W{1'b1}}) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ram_we    = '0;
        ram_addr  = tbl_if.cfg_addr;
        ram_wdata = tbl_if.cfg_wdata;
        if (busy) begin
            ram_we    = '1;
            ram_addr  = cnt_q;
            ram_wdata = CLEAR_VALUE;
        end else if (cfg_acc) begin
            ram_we = tbl_if.cfg_we;
        end
    end

    for (genvar b = 0; b < NB; b++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] cfg_q;
        logic [7:0] lk_q;

        // Read-first: a lookup in the write cycle sees the old byte; the
        // forwarding mask patches in the new one a stage later.
        always_ff @(posedge clk_i) begin
            if (ram_we[b]) begin
                mem[ram_addr] <= ram_wdata[8*b +: 8];
            end
            if (cfg_rd) begin
                cfg_q <= mem[tbl_if.cfg_addr];
            end
            if (lk_acc) begin
                lk_q <= mem[tbl_if.lk_addr];
            end
        end

        assign cfg_ram[8*b +: 8]   = cfg_q;
        assign lk_ram[8*b +: 8]    = lk_q;
        assign lk_merged[8*b +: 8] = lk_fwd_mask_q[b] ? lk_fwd_data_q[8*b +: 8] : lk_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cfg_seen_q    <= 1'b0;
            lk_v1_q       <= 1'b0;
            lk_v2_q       <= 1'b0;
            lk_fwd_mask_q <= '0;
            lk_fwd_data_q <= '0;
            lk_data_q     <= '0;
        end else begin
            if (cfg_rd) begin
                cfg_seen_q <= 1'b1;
            end
            lk_v1_q <= lk_acc;
            lk_v2_q <= lk_v1_q;
            if (lk_acc) begin
                lk_fwd_mask_q <= (cfg_acc && (tbl_if.cfg_addr == tbl_if.lk_addr)) ? tbl_if.cfg_we : '0;
                lk_fwd_data_q <= tbl_if.cfg_wdata;
            end
            if (lk_v1_q) begin
                lk_data_q <= lk_merged;
            end
        end
    end

    assign tbl_if.busy          = busy;
    assign tbl_if.cfg_ready     = ~busy;
    assign tbl_if.lk_req_ready  = ~busy;
    assign tbl_if.cfg_rdata     = cfg_seen_q ? cfg_ram : '0;
    assign tbl_if.lk_resp_valid = lk_v2_q;
    assign tbl_if.lk_resp_data  = lk_data_q;

endmodule

// File: tb/tb_next_hop_table.sv
// Directed bench for next_hop_table: clear timing, byte-lane config access,
// lookup pipeline, same-cycle forwarding, clear during traffic and reset mid-clear.
module tb_next_hop_table;
    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_err = 0;

    next_hop_table_if #(.DATA_W(32), .ADDR_W(11)) tbl_if ();

    next_hop_table #(
        .DATA_W(32), .ADDR_W(11), .CLEAR_VALUE(32'h0), .INIT_CLEAR(1'b1)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .tbl_if  (tbl_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs and samples both sit 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic count_busy(output int n);
        int g;
        n = 0;
        g = 0;
        while (tbl_if.busy === 1'b1 && g < 5000) begin
            n++;
            g++;
            step();
        end
    endtask

    task automatic cfg_write(input logic [10:0] a, input logic [3:0] we, input logic [31:0] d);
        tbl_if.cfg_en    = 1'b1;
        tbl_if.cfg_we    = we;
        tbl_if.cfg_addr  = a;
        tbl_if.cfg_wdata = d;
        step();
        tbl_if.cfg_en = 1'b0;
        tbl_if.cfg_we = '0;
    endtask

    task automatic cfg_read(input string tag, input logic [10:0] a, input logic [31:0] exp);
        tbl_if.cfg_en   = 1'b1;
        tbl_if.cfg_we   = '0;
        tbl_if.cfg_addr = a;
        step();
        tbl_if.cfg_en = 1'b0;
        chk(tag, tbl_if.cfg_rdata, exp);
    endtask

    task automatic lookup(input string tag, input logic [10:0] a, input logic [31:0] exp);
        tbl_if.lk_req_valid = 1'b1;
        tbl_if.lk_addr      = a;
        step();
        tbl_if.lk_req_valid = 1'b0;
        chk({tag, "_v+1"}, {31'd0, tbl_if.lk_resp_valid}, 32'd0);
        step();
        chk({tag, "_v+2"}, {31'd0, tbl_if.lk_resp_valid}, 32'd1);
        chk({tag, "_data"}, tbl_if.lk_resp_data, exp);
        step();
        chk({tag, "_v+3"}, {31'd0, tbl_if.lk_resp_valid}, 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, {31'd0, tbl_if.busy}, 32'd0);
        chk({tag, "_rdata"}, tbl_if.cfg_rdata, 32'd0);
        chk({tag, "_rvalid"}, {31'd0, tbl_if.lk_resp_valid}, 32'd0);
        chk({tag, "_rdata_lk"}, tbl_if.lk_resp_data, 32'd0);
    endtask

    logic [31:0] bb_exp [3];
    int          n;

    initial begin
        rst_n               = 1'b0;
        tbl_if.clear_start  = 1'b0;
        tbl_if.cfg_en       = 1'b0;
        tbl_if.cfg_we       = '0;
        tbl_if.cfg_addr     = '0;
        tbl_if.cfg_wdata    = '0;
        tbl_if.lk_req_valid = 1'b0;
        tbl_if.lk_addr      = '0;

        repeat (3) step();
        chk_reset_outputs("rst");

        rst_n = 1'b1;
        step();
        count_busy(n);
        chk("init_clear_len", n, 2048);
        chk("ready_after_clear", {30'd0, tbl_if.cfg_ready, tbl_if.lk_req_ready}, 32'd3);

        lookup("lk0", 11'd0, 32'h0);
        lookup("lk1023", 11'd1023, 32'h0);
        lookup("lk2047", 11'd2047, 32'h0);

        // Byte-lane write merge
        cfg_write(11'd5, 4'b1111, 32'hDEADBEEF);
        cfg_write(11'd5, 4'b0010, 32'h00007700);
        cfg_read("rd5", 11'd5, 32'hDEAD77EF);
        step();
        chk("rd5_hold", tbl_if.cfg_rdata, 32'hDEAD77EF);

        // Back-to-back lookups
        bb_exp[0] = 32'h01010101;
        bb_exp[1] = 32'h02020202;
        bb_exp[2] = 32'h03030303;
        for (int i = 0; i < 3; i++) cfg_write(11'(i + 1), 4'b1111, bb_exp[i]);
        for (int i = 0; i < 6; i++) begin
            if (i < 3) begin
                tbl_if.lk_req_valid = 1'b1;
                tbl_if.lk_addr      = 11'(i + 1);
            end else begin
                tbl_if.lk_req_valid = 1'b0;
            end
            step();
            if (i >= 1 && i <= 3) begin
                chk($sformatf("bb_v%0d", i), {31'd0, tbl_if.lk_resp_valid}, 32'd1);
                chk($sformatf("bb_d%0d", i), tbl_if.lk_resp_data, bb_exp[i-1]);
            end else begin
                chk($sformatf("bb_v%0d", i), {31'd0, tbl_if.lk_resp_valid}, 32'd0);
            end
        end
        chk("bb_hold", tbl_if.lk_resp_data, 32'h03030303);

        // Same-cycle write-to-lookup forwarding
        cfg_write(11'd9, 4'b1111, 32'h11223344);
        tbl_if.lk_req_valid = 1'b1;
        tbl_if.lk_addr      = 11'd9;
        tbl_if.cfg_en       = 1'b1;
        tbl_if.cfg_we       = 4'b0101;
        tbl_if.cfg_addr     = 11'd9;
        tbl_if.cfg_wdata    = 32'hAABBCCDD;
        step();
        tbl_if.cfg_en = 1'b0;
        tbl_if.cfg_we = '0;
        chk("fwd_v+1", {31'd0, tbl_if.lk_resp_valid}, 32'd0);
        step();
        tbl_if.lk_req_valid = 1'b0;
        chk("fwd_v", {31'd0, tbl_if.lk_resp_valid}, 32'd1);
        chk("fwd_merge", tbl_if.lk_resp_data, 32'h11BB33DD);
        step();
        chk("fwd_next_v", {31'd0, tbl_if.lk_resp_valid}, 32'd1);
        chk("fwd_next", tbl_if.lk_resp_data, 32'h11BB33DD);

        // A write one cycle after acceptance is not visible; other address independent
        tbl_if.lk_req_valid = 1'b1;
        tbl_if.lk_addr      = 11'd9;
        step();
        tbl_if.lk_addr   = 11'd5;
        tbl_if.cfg_en    = 1'b1;
        tbl_if.cfg_we    = 4'b1111;
        tbl_if.cfg_addr  = 11'd9;
        tbl_if.cfg_wdata = 32'hFFFFFFFF;
        step();
        tbl_if.lk_req_valid = 1'b0;
        tbl_if.cfg_addr     = 11'd6;
        tbl_if.cfg_wdata    = 32'h66666666;
        chk("late_wr_invisible", tbl_if.lk_resp_data, 32'h11BB33DD);
        step();
        tbl_if.cfg_en = 1'b0;
        tbl_if.cfg_we = '0;
        chk("indep_addr", tbl_if.lk_resp_data, 32'hDEAD77EF);
        cfg_read("rd9_late", 11'd9, 32'hFFFFFFFF);
        cfg_read("rd6", 11'd6, 32'h66666666);

        // Clear during traffic
        tbl_if.clear_start  = 1'b1;
        tbl_if.lk_req_valid = 1'b1;
        tbl_if.lk_addr      = 11'd3;
        step();
        tbl_if.clear_start = 1'b0;
        n = 0;
        if (tbl_if.busy === 1'b1) n++;
        chk("clr_rdy", {30'd0, tbl_if.cfg_ready, tbl_if.lk_req_ready}, 32'd0);
        tbl_if.clear_start = 1'b1;
        tbl_if.cfg_en      = 1'b1;
        tbl_if.cfg_we      = 4'b1111;
        tbl_if.cfg_addr    = 11'd3;
        tbl_if.cfg_wdata   = 32'h12345678;
        step();
        tbl_if.clear_start  = 1'b0;
        tbl_if.cfg_en       = 1'b0;
        tbl_if.cfg_we       = '0;
        tbl_if.lk_req_valid = 1'b0;
        if (tbl_if.busy === 1'b1) n++;
        chk("clr_inflight_v", {31'd0, tbl_if.lk_resp_valid}, 32'd1);
        chk("clr_inflight_d", tbl_if.lk_resp_data, 32'h03030303);
        step();
        chk("clr_drop_lk", {31'd0, tbl_if.lk_resp_valid}, 32'd0);
        begin
            int m;
            count_busy(m);
            n += m;
        end
        chk("clr_len", n, 2048);
        cfg_read("clr_drop_cfg", 11'd3, 32'h0);
        cfg_read("clr_rd5", 11'd5, 32'h0);

        // Reset mid-clear
        cfg_write(11'd7, 4'b1111, 32'hCAFEF00D);
        cfg_write(11'd2047, 4'b1111, 32'h5A5A5A5A);
        cfg_read("rd7", 11'd7, 32'hCAFEF00D);
        lookup("lk7", 11'd7, 32'hCAFEF00D);
        tbl_if.clear_start = 1'b1;
        step();
        tbl_if.clear_start = 1'b0;
        repeat (699) step();
        chk("mid_busy", {31'd0, tbl_if.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_rst");
        repeat (3) step();
        chk_reset_outputs("mid_rst_hold");
        rst_n = 1'b1;
        step();
        count_busy(n);
        chk("restart_len", n, 2048);
        cfg_read("restart_rd2047", 11'd2047, 32'h0);
        lookup("restart_lk7", 11'd7, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
